// File: rtl/instr_encoder.sv
// RV32I field packer: encodes opcode/register/immediate fields into a 32-bit instruction word
// behind a valid/ready interface with a registered output stage and a one-entry skid buffer.
module instr_encoder #(
  parameter int CNT_W         = 16,
  parameter bit ERR_ZERO_WORD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  // An immediate fits an N-bit signed field when all bits above N-1 equal the sign bit.
  function automatic logic fits_signed12(input logic [31:0] v);
    return (&v[31:11]) | ~(|v[31:11]);
  endfunction

  function automatic logic fits_signed13(input logic [31:0] v);
    return (&v[31:12]) | ~(|v[31:12]);
  endfunction

  function automatic logic fits_signed21(input logic [31:0] v);
    return (&v[31:20]) | ~(|v[31:20]);
  endfunction

  logic [31:0]      enc_word_s;
  logic [31:0]      enc_raw_s;
  logic             enc_err_s;

  logic             main_valid_r, main_valid_n;
  logic [31:0]      main_instr_r, main_instr_n;
  logic             main_err_r,   main_err_n;
  logic             skid_valid_r, skid_valid_n;
  logic [31:0]      skid_instr_r, skid_instr_n;
  logic             skid_err_r,   skid_err_n;
  logic             ready_r,      ready_n;
  logic [CNT_W-1:0] count_r,      count_n;
  logic             accept_s;
  logic             pop_s;

  // Field packing and range checking for the bundle currently on the input.
  always_comb begin
    enc_raw_s = 32'h0000_0000;
    enc_err_s = 1'b0;
    case (fmt)
      3'd0: begin
        enc_raw_s = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err_s = 1'b0;
      end
      3'd1: begin
        enc_raw_s = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err_s = ~fits_signed12(imm);
      end
      3'd2: begin
        enc_raw_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err_s = ~fits_signed12(imm);
      end
      3'd3: begin
        enc_raw_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err_s = ~fits_signed13(imm) | imm[0];
      end
      3'd4: begin
        enc_raw_s = {imm[31:12], rd, opcode};
        enc_err_s = (imm[11:0] != 12'h000);
      end
      3'd5: begin
        enc_raw_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err_s = ~fits_signed21(imm) | imm[0];
      end
      default: begin
        enc_raw_s = 32'h0000_0000;
        enc_err_s = 1'b1;
      end
    endcase
  end

  // Optional zeroing of words flagged as erroneous.
  always_comb begin
    if (ERR_ZERO_WORD && enc_err_s) begin
      enc_word_s = 32'h0000_0000;
    end else begin
      enc_word_s = enc_raw_s;
    end
  end

  assign accept_s = in_valid & ready_r;
  assign pop_s    = main_valid_r & out_ready;

  // Next-state for the output register, skid entry, ready flag and handoff counter.
  always_comb begin
    main_valid_n = main_valid_r;
    main_instr_n = main_instr_r;
    main_err_n   = main_err_r;
    skid_valid_n = skid_valid_r;
    skid_instr_n = skid_instr_r;
    skid_err_n   = skid_err_r;
    if (!main_valid_r || pop_s) begin
      // Output slot frees up: the skid entry is older than any new bundle, so it goes first.
      if (skid_valid_r) begin
        main_valid_n = 1'b1;
        main_instr_n = skid_instr_r;
        main_err_n   = skid_err_r;
        skid_valid_n = 1'b0;
      end else if (accept_s) begin
        main_valid_n = 1'b1;
        main_instr_n = enc_word_s;
        main_err_n   = enc_err_s;
      end else begin
        main_valid_n = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_n = 1'b1;
        skid_instr_n = enc_word_s;
        skid_err_n   = enc_err_s;
      end else begin
        skid_valid_n = skid_valid_r;
      end
    end
    ready_n = ~skid_valid_n;
    if (pop_s) begin
      count_n = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_n = count_r;
    end
  end

  // State registers; reset empties both entries and holds in_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_instr_r <= 32'h0000_0000;
      main_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_instr_r <= 32'h0000_0000;
      skid_err_r   <= 1'b0;
      ready_r      <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_n;
      main_instr_r <= main_instr_n;
      main_err_r   <= main_err_n;
      skid_valid_r <= skid_valid_n;
      skid_instr_r <= skid_instr_n;
      skid_err_r   <= skid_err_n;
      ready_r      <= ready_n;
      count_r      <= count_n;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = main_valid_r;
  assign out_instr = main_instr_r;
  assign out_err   = main_err_r;
  assign enc_count = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, randomized bundles with backpressure,
// skid/stall behaviour, mid-transfer reset and counter wrap.
module tb_instr_encoder;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] enc_count;

  int checks = 0;
  int errors = 0;

  logic [32:0]   exp_q[$];
  logic [CW-1:0] cnt_model;
  bit            hold;
  logic [31:0]   hold_w;
  logic          hold_e;

  instr_encoder #(.CNT_W(CW), .ERR_ZERO_WORD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // Reference: place fields arithmetically from the RV32I layouts; ranges from signed limits.
  function automatic void ref_enc(input int f, input int op, input int d, input int f3,
                                  input int s1, input int s2, input int f7, input int iv,
                                  output logic [31:0] w, output logic e);
    logic [31:0] u;
    logic [31:0] base;
    u = iv;
    base = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
    case (f)
      0: begin
        w = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20) | (32'(f7) << 25);
        e = 1'b0;
      end
      1: begin
        w = base | (32'(d) << 7) | ((u & 32'hFFF) << 20);
        e = (iv < -2048) || (iv > 2047);
      end
      2: begin
        w = base | (32'(s2) << 20) | ((u & 32'h1F) << 7) | (((u >> 5) & 32'h7F) << 25);
        e = (iv < -2048) || (iv > 2047);
      end
      3: begin
        w = base | (32'(s2) << 20) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7)
          | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
        e = (iv < -4096) || (iv > 4094) || ((iv & 1) != 0);
      end
      4: begin
        w = (u & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
        e = (u & 32'hFFF) != 32'h0;
      end
      5: begin
        w = 32'(op) | (32'(d) << 7) | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 32'h1) << 20)
          | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 32'h1) << 31);
        e = (iv < -1048576) || (iv > 1048574) || ((iv & 1) != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: count/stability checks every cycle, pops the scoreboard on each handoff.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_model = '0;
      hold = 1'b0;
    end else begin
      check("enc_count", 32'(enc_count), 32'(cnt_model));
      if (hold) begin
        check("stall_stable", {out_valid, out_err, out_instr[29:0]}, {1'b1, hold_e, hold_w[29:0]});
      end
      if (out_valid && out_ready) begin
        hold = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", out_instr);
        end else begin
          logic [32:0] ex;
          ex = exp_q.pop_front();
          check("out_instr", out_instr, ex[31:0]);
          check("out_err", 32'(out_err), 32'(ex[32]));
        end
        cnt_model = cnt_model + 1'b1;
      end else if (out_valid) begin
        hold = 1'b1;
        hold_w = out_instr;
        hold_e = out_err;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic set_fields(input int f, input int op, input int d, input int f3,
                            input int s1, input int s2, input int f7, input int iv);
    fmt = 3'(f); opcode = 7'(op); rd = 5'(d); funct3 = 3'(f3);
    rs1 = 5'(s1); rs2 = 5'(s2); funct7 = 7'(f7); imm = iv;
  endtask

  // Presents a bundle and pushes its expected word when the handshake will occur.
  task automatic send(input int f, input int op, input int d, input int f3, input int s1,
                      input int s2, input int f7, input int iv, input logic [31:0] ew, input logic ee);
    bit done;
    done = 1'b0;
    set_fields(f, op, d, f3, s1, s2, f7, iv);
    in_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ee, ew});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
  endtask

  task automatic send_model(input int f, input int op, input int d, input int f3, input int s1,
                            input int s2, input int f7, input int iv);
    logic [31:0] w;
    logic e;
    ref_enc(f, op, d, f3, s1, s2, f7, iv, w, e);
    send(f, op, d, f3, s1, s2, f7, iv, w, e);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 5))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 8191)) - 4096;
      2: return int'($urandom_range(0, 4194303)) - 2097152;
      3: return int'($urandom_range(0, 1048575)) << 12;
      4: begin
        int b[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 1048574, -1048576, 1048576};
        return b[$urandom_range(0, 9)];
      end
      default: return int'($urandom_range(0, 63)) * 2;
    endcase
  endfunction

  task automatic send_random();
    send_model(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 127)), rand_imm());
  endtask

  initial begin
    logic [CW-1:0] c0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(0, 'h33, 3, 0, 1, 2, 0, 0, 32'h002081B3, 1'b0);
    check("latency1_valid", 32'(out_valid), 32'd1);
    send(1, 'h13, 1, 0, 0, 0, 0, -1, 32'hFFF00093, 1'b0);
    send(2, 'h23, 0, 2, 1, 2, 0, 8, 32'h0020A423, 1'b0);
    send(3, 'h63, 0, 0, 0, 0, 0, -4, 32'hFE000EE3, 1'b0);
    send(5, 'h6F, 1, 0, 0, 0, 0, 2048, 32'h001000EF, 1'b0);
    send_model(1, 'h13, 1, 0, 0, 0, 0, 2048);
    exp_q[$][32] = 1'b1;
    send_model(3, 'h63, 0, 0, 0, 0, 0, 6);
    exp_q[$][32] = 1'b0;
    send_model(3, 'h63, 0, 0, 0, 0, 0, 5);
    exp_q[$][32] = 1'b1;
    send(7, 'h33, 5, 1, 2, 3, 4, 0, 32'h0, 1'b1);
    drain();

    // Back-to-back bundles into a stalled output: main, skid, then ready drops.
    c0 = enc_count;
    out_ready = 1'b0;
    send_model(0, 'h33, 1, 1, 1, 1, 1, 0);
    send_model(4, 'h37, 2, 0, 0, 0, 0, 32'h12345000);
    set_fields(1, 'h13, 3, 0, 4, 0, 0, 100);
    @(negedge clk);
    check("skid_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("skid_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_model(1, 'h13, 3, 0, 4, 0, 0, 100);
    drain();
    check("count_plus3", 32'(enc_count), 32'(CW'(c0 + CW'(3))));

    // Randomized bundles with random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) send_random();
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 1200; i++) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_any
    disable fork;
    drain();

    // Reset with both entries full discards them.
    out_ready = 1'b0;
    send_model(0, 'h33, 7, 0, 7, 7, 0, 0);
    send_model(0, 'h33, 8, 0, 8, 8, 0, 0);
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_enc_count", 32'(enc_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_word", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Counter wrap: 255 handoffs then one more.
    for (int i = 0; i < 255; i++) send_model(4, 'h17, 1, 0, 0, 0, 0, i << 12);
    drain();
    check("count_max", 32'(enc_count), 32'hFF);
    send_model(0, 'h33, 1, 2, 3, 4, 5, 0);
    drain();
    check("count_wrap", 32'(enc_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
